// File: rtl/memlcd_line_sched.sv
// rtl/memlcd_line_sched.sv - memory-LCD frame scheduler: mode/address/pixels/trailer framing with SCS setup/hold
// Optional MEMLCD_VCOM_EN: internal VCOM bit toggles per frame and rides in the mode byte.
module memlcd_line_sched #(
    parameter int BYTES_PER_LINE = 50,
    parameter int LINE_W         = 8,
    parameter int SCS_SETUP      = 3,
    parameter int SCS_HOLD       = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic [LINE_W-1:0] i_first_line,
    input  logic [LINE_W-1:0] i_num_lines,
    input  logic              i_fifo_empty,
    input  logic [7:0]        i_fifo_data,
    output logic              o_fifo_rd,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_valid,
    input  logic              i_tx_ready,
    input  logic              i_tx_busy,
    output logic              o_scs,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_stall
);

    localparam int BW = $clog2(BYTES_PER_LINE + 1);
    localparam logic [BW-1:0] BPL      = BW'(BYTES_PER_LINE);
    localparam logic [BW-1:0] BYTE_ONE = BW'(1);
    localparam logic [15:0] SETUP_LAST = 16'((SCS_SETUP > 0) ? SCS_SETUP - 1 : 0);
    localparam logic [15:0] HOLD_LAST  = 16'((SCS_HOLD > 0) ? SCS_HOLD - 1 : 0);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SETUP  = 4'd1;
    localparam logic [3:0] S_CMD    = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_DATA   = 4'd4;
    localparam logic [3:0] S_LTRAIL = 4'd5;
    localparam logic [3:0] S_FTRAIL = 4'd6;
    localparam logic [3:0] S_DRAIN  = 4'd7;
    localparam logic [3:0] S_HOLD   = 4'd8;

    logic [3:0]        state;
    logic [15:0]       tcnt;
    logic [BW-1:0]     bytes_left;
    logic [LINE_W-1:0] lines_left;
    logic [LINE_W-1:0] line_addr;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              scs;
    logic              frame_done;
    logic              vcom;
    logic              reg_free;
    logic              fifo_rd;
    logic              done_set;
    logic [7:0]        mode_byte;

    assign reg_free  = !tx_valid || i_tx_ready;
    assign fifo_rd   = !i_rst && (state == S_DATA) && (bytes_left != '0)
                       && !i_fifo_empty && reg_free;
    assign mode_byte = 8'h80 | {1'b0, vcom, 6'b0};

    // Both the zero-line no-op and the end of HOLD produce the frame_done pulse.
    assign done_set = ((state == S_IDLE) && i_frame_start && (i_num_lines == '0))
                      || ((state == S_HOLD) && (tcnt >= HOLD_LAST));

`ifdef MEMLCD_VCOM_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vcom <= 1'b0;
        end else if (done_set) begin
            vcom <= ~vcom;
        end
    end
`else
    assign vcom = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            tcnt       <= '0;
            bytes_left <= '0;
            lines_left <= '0;
            line_addr  <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            scs        <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_set;
            if (tx_valid && i_tx_ready) begin
                tx_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (i_frame_start && (i_num_lines != '0)) begin
                        line_addr  <= i_first_line;
                        lines_left <= i_num_lines;
                        tcnt       <= '0;
                        scs        <= 1'b1;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (tcnt >= SETUP_LAST) begin
                        state <= S_CMD;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                S_CMD: begin
                    if (reg_free) begin
                        tx_data  <= mode_byte;
                        tx_valid <= 1'b1;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (reg_free) begin
                        tx_data    <= 8'(line_addr);
                        tx_valid   <= 1'b1;
                        bytes_left <= BPL;
                        state      <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Leave on the last pop so the trailer follows without a bubble.
                    if (fifo_rd) begin
                        tx_data    <= i_fifo_data;
                        tx_valid   <= 1'b1;
                        bytes_left <= bytes_left - BYTE_ONE;
                        if (bytes_left == BYTE_ONE) begin
                            state <= S_LTRAIL;
                        end
                    end
                end
                S_LTRAIL: begin
                    if (reg_free) begin
                        tx_data    <= 8'h00;
                        tx_valid   <= 1'b1;
                        line_addr  <= line_addr + LINE_ONE;
                        lines_left <= lines_left - LINE_ONE;
                        state      <= (lines_left == LINE_ONE) ? S_FTRAIL : S_ADDR;
                    end
                end
                S_FTRAIL: begin
                    if (reg_free) begin
                        tx_data  <= 8'h00;
                        tx_valid <= 1'b1;
                        state    <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_valid && !i_tx_busy) begin
                        tcnt  <= '0;
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (tcnt >= HOLD_LAST) begin
                        scs   <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + 16'd1;
                    end
                end
                default: begin
                    scs   <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_fifo_rd    = fifo_rd;
    assign o_tx_data    = tx_data;
    assign o_tx_valid   = tx_valid;
    assign o_scs        = scs;
    assign o_busy       = (state != S_IDLE);
    assign o_frame_done = frame_done;
    assign o_stall      = (state == S_DATA) && (bytes_left != '0) && i_fifo_empty;

endmodule

// File: tb/tb_memlcd_line_sched.sv
// tb/tb_memlcd_line_sched.sv - randomized self-checking bench for memlcd_line_sched
module tb_memlcd_line_sched;

    localparam int BPL = 2;
    localparam int LW  = 8;
    localparam int SU  = 3;
    localparam int HD  = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_frame_start;
    logic [LW-1:0] i_first_line;
    logic [LW-1:0] i_num_lines;
    logic          i_fifo_empty;
    logic [7:0]    i_fifo_data;
    logic          o_fifo_rd;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_ready;
    logic          i_tx_busy;
    logic          o_scs;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_stall;

    memlcd_line_sched #(
        .BYTES_PER_LINE(BPL),
        .LINE_W(LW),
        .SCS_SETUP(SU),
        .SCS_HOLD(HD)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_frame_start(i_frame_start),
        .i_first_line(i_first_line),
        .i_num_lines(i_num_lines),
        .i_fifo_empty(i_fifo_empty),
        .i_fifo_data(i_fifo_data),
        .o_fifo_rd(o_fifo_rd),
        .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready),
        .i_tx_busy(i_tx_busy),
        .o_scs(o_scs),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done),
        .o_stall(o_stall)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] q_fifo[$];
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] pend_data[$];
    int  ready_mode = 0;
    int  gap_pct = 0;
    bit  gap_force = 1'b0;
    int  busy_cnt = 0;
    int  pops = 0;
    int  hold_viol = 0;
    int  empty_pop_viol = 0;
    bit  exp_vcom = 1'b0;
    bit  pend_pop = 1'b0;
    bit  pend_acc = 1'b0;
    bit  prev_hold = 1'b0;
    logic [7:0] acc_data = 8'h00;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] tmp_b;
    int  checks = 0;
    int  passed = 0;

    // Serializer / FIFO environment, driven and sampled on the falling edge.
    always @(negedge i_clk) begin
        if (pend_pop && q_fifo.size() > 0) tmp_b = q_fifo.pop_front();
        if (pend_acc) begin
            got.push_back(acc_data);
            busy_cnt = 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        case (ready_mode)
            0: i_tx_ready = 1'b1;
            1: i_tx_ready = !i_tx_ready;
            default: i_tx_ready = 1'($urandom_range(0, 1));
        endcase
        i_tx_busy    = (busy_cnt > 0);
        i_fifo_empty = gap_force || ($urandom_range(0, 99) < gap_pct) || (q_fifo.size() == 0);
        i_fifo_data  = i_fifo_empty ? 8'($urandom) : q_fifo[0];
        #1;
        if (!i_rst && prev_hold && !(o_tx_valid && o_tx_data == prev_data)) hold_viol++;
        if (o_fifo_rd && i_fifo_empty) empty_pop_viol++;
        pend_pop  = o_fifo_rd && !i_rst;
        if (pend_pop) pops++;
        pend_acc  = !i_rst && o_tx_valid && i_tx_ready;
        acc_data  = o_tx_data;
        prev_hold = !i_rst && o_tx_valid && !i_tx_ready;
        prev_data = o_tx_data;
    end

    task automatic build_frame(input logic [7:0] first, input int n, input bit fixed, input bit hold_back);
        logic [7:0] d;
        exp_q.delete();
        got.delete();
        pend_data.delete();
        pops = 0;
        exp_q.push_back(exp_vcom ? 8'hC0 : 8'h80);
        for (int l = 0; l < n; l++) begin
            exp_q.push_back(8'(first + 8'(l)));
            for (int b = 0; b < BPL; b++) begin
                d = fixed ? 8'(8'hAA + 8'(17 * b)) : 8'($urandom);
                exp_q.push_back(d);
                pend_data.push_back(d);
            end
            exp_q.push_back(8'h00);
        end
        exp_q.push_back(8'h00);
        if (!hold_back) begin
            foreach (pend_data[i]) q_fifo.push_back(pend_data[i]);
        end
    endtask

    task automatic pulse_start(input logic [7:0] first, input logic [7:0] n);
        @(negedge i_clk);
        i_first_line  = first;
        i_num_lines   = n;
        i_frame_start = 1'b1;
        @(negedge i_clk);
        i_frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            #2;
            if (o_frame_done) begin
                ok = 1'b1;
                break;
            end
        end
`ifdef MEMLCD_VCOM_EN
        if (ok) exp_vcom = !exp_vcom;
`endif
    endtask

    task automatic check_frame(input string name, input int n);
        int bad;
        bad = 0;
        checks++;
        if (got.size() !== exp_q.size()) begin
            $display("FAIL %s_len: got %0d bytes, expected %0d", name, got.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) if (got[i] !== exp_q[i]) bad++;
            if (bad != 0) $display("FAIL %s_data: %0d byte(s) differ, first got %h expected %h", name, bad, got[0], exp_q[0]);
            else passed++;
        end
        checks++;
        if (pops !== n * BPL) $display("FAIL %s_pops: got %0d expected %0d", name, pops, n * BPL);
        else passed++;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        i_frame_start = 1'b0;
        i_first_line = '0;
        i_num_lines = '0;
        repeat (3) @(negedge i_clk);
        #2;
        checks++;
        if ({o_scs, o_tx_valid, o_busy, o_frame_done, o_stall, o_fifo_rd} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {o_scs, o_tx_valid, o_busy, o_frame_done, o_stall, o_fifo_rd});
        else passed++;
        checks++;
        if (o_tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", o_tx_data);
        else passed++;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_vcom = 1'b0;
    endtask

    task automatic test_basic;
        bit ok;
        int k;
        int bub;
        logic [7:0] lit[6];
        lit = '{8'h80, 8'h05, 8'hAA, 8'hBB, 8'h00, 8'h00};
        ready_mode = 0;
        gap_pct = 0;
        build_frame(8'h05, 1, 1'b1, 1'b0);
        pulse_start(8'h05, 8'd1);
        #2;
        checks++;
        if (!(o_busy && o_scs && !o_tx_valid)) $display("FAIL start_edge: busy=%b scs=%b valid=%b expected 1 1 0", o_busy, o_scs, o_tx_valid);
        else passed++;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            #2;
            if (o_tx_valid) begin
                k = i;
                break;
            end
        end
        checks++;
        if (k !== SU + 1) $display("FAIL setup_latency: got %0d clocks expected %0d", k, SU + 1);
        else passed++;
        bub = 0;
        for (int i = 1; i < 6; i++) begin
            @(negedge i_clk);
            #2;
            if (!o_tx_valid) bub++;
        end
        checks++;
        if (bub !== 0) $display("FAIL no_bubbles: got %0d idle cycles expected 0", bub);
        else passed++;
        wait_done(ok);
        checks++;
        if (!ok || o_busy || o_scs) $display("FAIL basic_done: seen=%b busy=%b scs=%b expected 1 0 0", ok, o_busy, o_scs);
        else passed++;
        check_frame("basic", 1);
        checks++;
        if (got.size() != 6 || got[0] !== lit[0] || got[1] !== lit[1] || got[2] !== lit[2] ||
            got[3] !== lit[3] || got[4] !== lit[4] || got[5] !== lit[5])
            $display("FAIL basic_literal: got %0d bytes, expected 80 05 AA BB 00 00", got.size());
        else passed++;
        @(negedge i_clk);
        #2;
        checks++;
        if (o_frame_done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", o_frame_done);
        else passed++;
    endtask

    task automatic test_wrap;
        bit ok;
        ready_mode = 2;
        gap_pct = 0;
        build_frame(8'hFE, 3, 1'b0, 1'b0);
        pulse_start(8'hFE, 8'd3);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL wrap_done: got timeout expected frame_done");
        else passed++;
        check_frame("wrap", 3);
    endtask

    task automatic test_underrun;
        bit ok;
        int bad;
        bit seen;
        ready_mode = 0;
        gap_pct = 0;
        build_frame(8'h10, 1, 1'b0, 1'b1);
        q_fifo.push_back(pend_data[0]);
        pulse_start(8'h10, 8'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            #2;
            if (o_stall) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) $display("FAIL stall_seen: got 0 expected o_stall=1");
        else passed++;
        @(negedge i_clk);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            #2;
            if (!(o_stall && !o_tx_valid && o_scs && !o_fifo_rd)) bad++;
        end
        checks++;
        if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", bad);
        else passed++;
        q_fifo.push_back(pend_data[1]);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL underrun_done: got timeout expected frame_done");
        else passed++;
        check_frame("underrun", 1);
    endtask

    task automatic test_alt_ready;
        bit ok;
        ready_mode = 1;
        gap_pct = 20;
        hold_viol = 0;
        build_frame(8'h40, 2, 1'b0, 1'b0);
        pulse_start(8'h40, 8'd2);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL alt_done: got timeout expected frame_done");
        else passed++;
        check_frame("alt_ready", 2);
        checks++;
        if (hold_viol !== 0) $display("FAIL alt_hold: got %0d unstable cycles expected 0", hold_viol);
        else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        bit seen;
        int dn;
        ready_mode = 0;
        gap_pct = 0;
        build_frame(8'h20, 3, 1'b0, 1'b0);
        pulse_start(8'h20, 8'd3);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge i_clk);
            if (got.size() >= BPL + 4) begin
                seen = 1'b1;
                break;
            end
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        #2;
        checks++;
        if (!seen || o_scs || o_busy || o_tx_valid || o_frame_done)
            $display("FAIL rst_mid: line2=%b scs=%b busy=%b valid=%b done=%b expected 1 0 0 0 0", seen, o_scs, o_busy, o_tx_valid, o_frame_done);
        else passed++;
        checks++;
        if (q_fifo.size() !== 3 * BPL - pops) $display("FAIL rst_fifo: got %0d left expected %0d", q_fifo.size(), 3 * BPL - pops);
        else passed++;
        @(negedge i_clk);
        i_rst = 1'b0;
        exp_vcom = 1'b0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            #2;
            if (o_frame_done || o_busy) dn++;
        end
        checks++;
        if (dn !== 0) $display("FAIL rst_quiet: got %0d active cycles expected 0", dn);
        else passed++;
        q_fifo.delete();
        build_frame(8'h30, 2, 1'b0, 1'b0);
        pulse_start(8'h30, 8'd2);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL rst_clean_done: got timeout expected frame_done");
        else passed++;
        check_frame("after_reset", 2);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int act;
        ready_mode = 0;
        gap_pct = 0;
        build_frame(8'h60, 1, 1'b0, 1'b0);
        pulse_start(8'h60, 8'd1);
        wait_done(ok);
        check_frame("b2b_first", 1);
        build_frame(8'h70, 1, 1'b0, 1'b0);
        pulse_start(8'h70, 8'd1);
        repeat (3) @(negedge i_clk);
        pulse_start(8'h90, 8'd5);
        wait_done(ok);
        checks++;
        if (!ok) $display("FAIL b2b_done: got timeout expected frame_done");
        else passed++;
        check_frame("b2b_second", 1);
        act = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            #2;
            if (o_busy || o_scs) act++;
        end
        checks++;
        if (act !== 0) $display("FAIL b2b_ignored_start: got %0d busy cycles expected 0", act);
        else passed++;
    endtask

    task automatic test_noop;
        pulse_start(8'h12, 8'd0);
        #2;
        checks++;
        if (!(o_frame_done && !o_busy && !o_scs)) $display("FAIL noop_done: done=%b busy=%b scs=%b expected 1 0 0", o_frame_done, o_busy, o_scs);
        else passed++;
`ifdef MEMLCD_VCOM_EN
        exp_vcom = !exp_vcom;
`endif
        @(negedge i_clk);
        #2;
        checks++;
        if (o_frame_done || o_busy) $display("FAIL noop_single: done=%b busy=%b expected 0 0", o_frame_done, o_busy);
        else passed++;
    endtask

    task automatic test_random;
        bit ok;
        int n;
        logic [7:0] first;
        ready_mode = 2;
        gap_pct = 25;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 4);
            first = 8'($urandom);
            build_frame(first, n, 1'b0, 1'b0);
            pulse_start(first, 8'(n));
            wait_done(ok);
            checks++;
            if (!ok) $display("FAIL rand_done: frame %0d got timeout expected frame_done", f);
            else passed++;
            check_frame("random", n);
        end
        checks++;
        if (empty_pop_viol !== 0) $display("FAIL empty_pop: got %0d pops while empty expected 0", empty_pop_viol);
        else passed++;
    endtask

    initial begin
        i_tx_ready = 1'b1;
        i_tx_busy = 1'b0;
        i_fifo_empty = 1'b1;
        i_fifo_data = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_underrun();
        test_alt_ready();
        test_reset_mid();
        test_back_to_back();
        test_noop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
